dff_trace_capture: RTL and testbench
====================================

DFF_TRACE_CAPTURE -- requirements
Module: dff_trace_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TS_W, default 16, timestamp width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port smp_rst_n  input  1  observed flip-flop reset.
REQ-006 SHALL have port smp_enable  input  1  observed flip-flop enable.
REQ-007 SHALL have port smp_d  input  1  observed flip-flop data input.
REQ-008 SHALL have port smp_q  input  1  observed flip-flop output.
REQ-009 SHALL have port capture_en  input  1  sample-this-cycle request.
REQ-010 SHALL have port out_valid  output  1  head entry available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-012 SHALL have port out_data  output  TS_W+4  {timestamp, rst_n, enable, d, q}, q in bit 0.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port overflow  output  1  sticky: a sample was dropped.

Function
REQ-015 SHALL increment an internal TS_W-bit timestamp every clk edge, starting at 0 on the first edge after reset, wrapping from all-ones to 0.
REQ-016 SHALL, on an edge with capture_en=1, push {timestamp, smp_rst_n, smp_enable, smp_d, smp_q} as sampled at that edge.
REQ-017 SHALL pop the head entry on an edge with out_valid=1 and out_ready=1; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 SHALL present out_valid=1 on the edge after the first push into an empty FIFO (1-cycle latency); out_data SHALL be the oldest unpopped entry.
REQ-019 SHALL drop the push when full and not popping in the same edge, set overflow=1, and leave count at DEPTH.
REQ-020 SHALL accept a push when full and a pop occurs in the same edge; count unchanged.
REQ-021 SHALL perform simultaneous push and pop when empty as push only (no pop of absent data).
REQ-022 SHALL keep count equal to pushes minus pops; pointer wrap-around SHALL not corrupt ordering.
REQ-023 SHALL hold overflow at 1 until rst.

Reset
REQ-024 SHALL, while rst=1, immediately force out_valid=0, count=0, overflow=0, timestamp=0, FIFO pointers=0, out_data=0.
REQ-025 SHALL discard all FIFO contents on rst mid-operation; the first push after release SHALL carry timestamp 0.

Configuration
REQ-026 SHALL, with macro DFF_TRACE_CHECK_EN defined, add outputs mismatch (1, sticky) and mismatch_cnt (16, saturating at 16'hFFFF), both 0 on reset.
REQ-027 SHALL, with DFF_TRACE_CHECK_EN, compute expected q per edge regardless of capture_en: 0 if smp_rst_n=0; else 0 if previous smp_rst_n=0; else previous smp_d if previous smp_enable=1; else previous expected q.
REQ-028 SHALL, with DFF_TRACE_CHECK_EN, compare smp_q to expected q on every edge except the first after rst, and on inequality set mismatch and increment mismatch_cnt.
REQ-029 SHALL, without DFF_TRACE_CHECK_EN, omit mismatch, mismatch_cnt and all checker logic; FIFO behaviour unchanged.

Verification
REQ-030 SHALL verify: rst pulse, capture_en=1 for 3 edges, out_ready=0 -> count=3, out_data timestamp 0, out_valid=1 from edge 2.
REQ-031 SHALL verify: DEPTH=16, capture_en=1 for 18 edges, out_ready=0 -> count=16, overflow=1, head timestamp 0.
REQ-032 SHALL verify: full FIFO, capture_en=1 and out_ready=1 for 20 edges -> count stays 16, overflow stays 0, popped timestamps consecutive.
REQ-033 SHALL verify: TS_W=4, capture every edge, drain continuously -> timestamps 14,15,0,1 in order.
REQ-034 SHALL verify (DFF_TRACE_CHECK_EN): rst_n=1,enable=1,d=1 then smp_q=0 on next edge -> mismatch=1, mismatch_cnt=1; correct q sequence -> mismatch_cnt=0.
REQ-035 SHALL verify: rst asserted mid-drain with count=5 -> out_valid=0 and count=0 without waiting for a clk edge.

Source files
------------

// File: rtl/dff_trace_capture.sv
// Timestamped trace FIFO that samples an observed flip-flop's pins on request.
// Optional macro DFF_TRACE_CHECK_EN adds an on-line reference check of smp_q.
module dff_trace_capture #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     smp_rst_n,
    input  logic                     smp_enable,
    input  logic                     smp_d,
    input  logic                     smp_q,
    input  logic                     capture_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W+3:0]          out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef DFF_TRACE_CHECK_EN
    ,
    output logic                     mismatch,
    output logic [15:0]              mismatch_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = TS_W + 4;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TS_W-1:0] ts;
    logic            full;
    logic            pop;
    logic            push;

    // Handshake: an entry transfers on any edge where out_valid and out_ready are both 1;
    // out_data is held while out_valid=1 and out_ready=0.
    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = capture_en & (~full | pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ts, smp_rst_n, smp_enable, smp_d, smp_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ts       <= '0;
            overflow <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            // A request that finds the FIFO full with no pop this edge is lost.
            if (capture_en & full & ~pop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef DFF_TRACE_CHECK_EN
    logic prev_rst_n;
    logic prev_en;
    logic prev_d;
    logic prev_exp;
    logic chk_armed;
    logic exp_q;

    always_comb begin
        exp_q = 1'b0;
        if (smp_rst_n && prev_rst_n) begin
            exp_q = prev_en ? prev_d : prev_exp;
        end
    end

    // The first edge after rst has no history, so it is never compared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_rst_n   <= 1'b0;
            prev_en      <= 1'b0;
            prev_d       <= 1'b0;
            prev_exp     <= 1'b0;
            chk_armed    <= 1'b0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            prev_rst_n <= smp_rst_n;
            prev_en    <= smp_enable;
            prev_d     <= smp_d;
            prev_exp   <= exp_q;
            chk_armed  <= 1'b1;
            if (chk_armed && (smp_q != exp_q)) begin
                mismatch <= 1'b1;
                if (mismatch_cnt != 16'hFFFF) begin
                    mismatch_cnt <= mismatch_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dff_trace_capture.sv
// Bench for dff_trace_capture: queue-based reference model, per-cycle compare, directed pins.
module tb_dff_trace_capture;
    localparam int DEPTH = 16;
    localparam int TS_W  = 16;
    localparam int DW    = TS_W + 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic smp_rst_n, smp_enable, smp_d, smp_q, capture_en, out_ready;
    logic out_valid, overflow;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;

    logic cap4, rdy4, valid4, ovf4;
    logic [7:0] data4;
    logic [2:0] count4;

`ifdef DFF_TRACE_CHECK_EN
    logic mismatch, mm4;
    logic [15:0] mismatch_cnt, mmc4;
`endif

    dff_trace_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst), .smp_rst_n(smp_rst_n), .smp_enable(smp_enable),
        .smp_d(smp_d), .smp_q(smp_q), .capture_en(capture_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .overflow(overflow)
`ifdef DFF_TRACE_CHECK_EN
        , .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
`endif
    );

    dff_trace_capture #(.DEPTH(4), .TS_W(4)) dut4 (
        .clk(clk), .rst(rst), .smp_rst_n(smp_rst_n), .smp_enable(smp_enable),
        .smp_d(smp_d), .smp_q(smp_q), .capture_en(cap4),
        .out_valid(valid4), .out_ready(rdy4), .out_data(data4),
        .count(count4), .overflow(ovf4)
`ifdef DFF_TRACE_CHECK_EN
        , .mismatch(mm4), .mismatch_cnt(mmc4)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0]   exp_q[$];
    logic [TS_W-1:0] m_ts;
    logic            m_ovf;
    bit              m_pop, m_push;
`ifdef DFF_TRACE_CHECK_EN
    logic        m_mm, pm_rst_n, pm_en, pm_d, pm_exp, pm_first, m_e;
    logic [15:0] m_mmc;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_ts  = '0;
            m_ovf = 1'b0;
`ifdef DFF_TRACE_CHECK_EN
            m_mm = 0; m_mmc = 0; pm_rst_n = 0; pm_en = 0; pm_d = 0; pm_exp = 0; pm_first = 1;
`endif
        end else begin
            m_pop  = (exp_q.size() > 0) && out_ready;
            m_push = capture_en && ((exp_q.size() < DEPTH) || m_pop);
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) exp_q.push_back({m_ts, smp_rst_n, smp_enable, smp_d, smp_q});
            else if (capture_en) m_ovf = 1'b1;
            m_ts = m_ts + 1'b1;
`ifdef DFF_TRACE_CHECK_EN
            if (!smp_rst_n || !pm_rst_n) m_e = 1'b0;
            else m_e = pm_en ? pm_d : pm_exp;
            if (!pm_first && (smp_q !== m_e)) begin
                m_mm = 1'b1;
                if (m_mmc != 16'hFFFF) m_mmc = m_mmc + 16'd1;
            end
            pm_rst_n = smp_rst_n; pm_en = smp_enable; pm_d = smp_d; pm_exp = m_e; pm_first = 0;
`endif
        end
    end

    logic [DW-1:0] m_head;
    always @(negedge clk) begin
        m_head = (exp_q.size() > 0) ? exp_q[0] : '0;
        check("count", 32'(count), 32'(exp_q.size()));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("out_data", 32'(out_data), 32'(m_head));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef DFF_TRACE_CHECK_EN
        check("mismatch", 32'(mismatch), 32'(m_mm));
        check("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mmc));
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        capture_en = 0; out_ready = 0; cap4 = 0; rdy4 = 0;
        smp_rst_n = 1; smp_enable = 0; smp_d = 0; smp_q = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic rand_smp();
        smp_rst_n  = ($urandom_range(0, 9) != 0);
        smp_enable = 1'($urandom_range(0, 1));
        smp_d      = 1'($urandom_range(0, 1));
        smp_q      = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [31:0] head_ts();
        return 32'(out_data[DW-1:4]);
    endfunction

    logic [3:0] wrap_seen [4];
    logic       prev_d_drv;

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // three captures, consumer stalled
        do_reset();
        capture_en = 1;
        step();
        check("valid_after_first_push", 32'(out_valid), 32'd1);
        step();
        step();
        capture_en = 0;
        check("three_count", 32'(count), 32'd3);
        check("three_head_ts", head_ts(), 32'd0);
        step();
        check("stall_hold_ts", head_ts(), 32'd0);

        // overfill by two
        do_reset();
        capture_en = 1;
        repeat (18) step();
        capture_en = 0;
        check("overfill_count", 32'(count), 32'd16);
        check("overfill_flag", 32'(overflow), 32'd1);
        check("overfill_head_ts", head_ts(), 32'd0);
        repeat (3) step();
        check("overflow_sticky", 32'(overflow), 32'd1);

        // full FIFO with simultaneous push and pop
        do_reset();
        capture_en = 1;
        repeat (16) step();
        check("full_count", 32'(count), 32'd16);
        out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("full_pp_count", 32'(count), 32'd16);
        end
        check("full_pp_overflow", 32'(overflow), 32'd0);
        check("full_pp_head_ts", head_ts(), 32'd20);
        capture_en = 0;
        repeat (16) step();
        check("drained_count", 32'(count), 32'd0);

        // empty FIFO push+pop is a push only
        do_reset();
        capture_en = 1; out_ready = 1;
        step();
        check("empty_pp_count", 32'(count), 32'd1);

        // asynchronous reset in the middle of a drain
        do_reset();
        capture_en = 1;
        repeat (7) step();
        capture_en = 0; out_ready = 1;
        repeat (2) step();
        check("middrain_count", 32'(count), 32'd5);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        step();
        rst = 1'b0;
        capture_en = 1; out_ready = 0;
        step();
        capture_en = 0;
        check("post_rst_ts", head_ts(), 32'd0);

        // randomized traffic with varied fill/drain bias
        for (int ph = 0; ph < 4; ph++) begin
            do_reset();
            for (int i = 0; i < 250; i++) begin
                capture_en = ($urandom_range(0, 99) < 40 + 15 * ph);
                out_ready  = ($urandom_range(0, 99) < 75 - 15 * ph);
                rand_smp();
                step();
            end
        end

`ifdef DFF_TRACE_CHECK_EN
        // a well-behaved flop produces no mismatches
        do_reset();
        smp_rst_n = 0; smp_enable = 0; smp_d = 0; smp_q = 0;
        step();
        prev_d_drv = 0;
        for (int i = 1; i < 12; i++) begin
            smp_rst_n = 1; smp_enable = 1;
            smp_q = (i == 1) ? 1'b0 : prev_d_drv;
            smp_d = 1'($urandom_range(0, 1));
            prev_d_drv = smp_d;
            step();
        end
        check("good_seq_cnt", 32'(mismatch_cnt), 32'd0);
        check("good_seq_flag", 32'(mismatch), 32'd0);
        smp_q = prev_d_drv; smp_d = 1; smp_enable = 1; smp_rst_n = 1;
        step();
        smp_q = 0; smp_d = 0;
        step();
        check("bad_q_flag", 32'(mismatch), 32'd1);
        check("bad_q_cnt", 32'(mismatch_cnt), 32'd1);
`endif

        // narrow timestamp wrap on the small instance
        do_reset();
        cap4 = 1; rdy4 = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("wrap_valid", 32'(valid4), 32'd1);
            check("wrap_count", 32'(count4), 32'd1);
            check("wrap_ts", 32'(data4[7:4]), 32'(k % 16));
            if (k >= 14 && k < 18) wrap_seen[k-14] = data4[7:4];
        end
        check("wrap_seq0", 32'(wrap_seen[0]), 32'd14);
        check("wrap_seq1", 32'(wrap_seen[1]), 32'd15);
        check("wrap_seq2", 32'(wrap_seen[2]), 32'd0);
        check("wrap_seq3", 32'(wrap_seen[3]), 32'd1);
        check("wrap_no_overflow", 32'(ovf4), 32'd0);
        cap4 = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
